// File: rtl/miriscv_timer.sv
// miriscv_timer: memory-mapped prescaled compare timer with a level interrupt request
module miriscv_timer #(
   parameter int PRESC_W = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        dev_req_i,
   input  logic        dev_we_i,
   input  logic [3:0]  dev_mask_i,
   input  logic [31:0] dev_addr_i,
   input  logic [31:0] dev_wr_data_i,
   output logic [31:0] dev_data_o,
   input  logic        int_rst_i,
   output logic        int_req_o
);
   logic en_q, en_d, ar_q, ar_d, ie_q, ie_d, pend_q, pend_d;
   logic [31:0] count_q, count_d, cmp_q, cmp_d, data_q, data_d, rdata, presc_ext;
   logic [PRESC_W-1:0] presc_q, presc_d, pcnt_q, pcnt_d;
   logic wr, rd, tick, match, ctrl_wr, unused_addr;
   logic [3:0] sel_wr;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] m);
      for (int b = 0; b < 4; b++) if (m[b]) old[b*8 +: 8] = wd[b*8 +: 8];
      return old;
   endfunction

   assign unused_addr = ^{dev_addr_i[31:4], dev_addr_i[1:0]};

   always_comb begin
      wr = dev_req_i & dev_we_i;
      rd = dev_req_i & ~dev_we_i;
      sel_wr = wr ? 4'b0001 << dev_addr_i[3:2] : 4'b0000;
      ctrl_wr = sel_wr[0] & dev_mask_i[0];
      presc_ext = 32'(presc_q);
      tick = en_q & (pcnt_q == presc_q);
      match = count_q == cmp_q;
      pcnt_d = (en_q & ~tick) ? pcnt_q + 1'b1 : '0;
      count_d = sel_wr[1] ? merge(count_q, dev_wr_data_i, dev_mask_i) :
                !tick     ? count_q :
                !match    ? count_q + 32'd1 :
                ar_q      ? '0 : count_q;
      cmp_d = sel_wr[2] ? merge(cmp_q, dev_wr_data_i, dev_mask_i) : cmp_q;
      presc_d = sel_wr[3] ? PRESC_W'(merge(presc_ext, dev_wr_data_i, dev_mask_i)) : presc_q;
      // a bus write of EN wins over the one-shot self-disable
      en_d = ctrl_wr ? dev_wr_data_i[0] : (tick & match & ~ar_q) ? 1'b0 : en_q;
      ar_d = ctrl_wr ? dev_wr_data_i[1] : ar_q;
      ie_d = ctrl_wr ? dev_wr_data_i[2] : ie_q;
      pend_d = (tick & match) | (pend_q & ~int_rst_i & ~(ctrl_wr & dev_wr_data_i[3]));
      rdata = (dev_addr_i[3:2] == 2'd0) ? {28'd0, pend_q, ie_q, ar_q, en_q} :
              (dev_addr_i[3:2] == 2'd1) ? count_q :
              (dev_addr_i[3:2] == 2'd2) ? cmp_q : presc_ext;
      data_d = rd ? rdata : data_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         en_q    <= 1'b0;
         ar_q    <= 1'b0;
         ie_q    <= 1'b0;
         pend_q  <= 1'b0;
         count_q <= '0;
         cmp_q   <= '1;
         presc_q <= '0;
         pcnt_q  <= '0;
         data_q  <= '0;
      end else begin
         en_q    <= en_d;
         ar_q    <= ar_d;
         ie_q    <= ie_d;
         pend_q  <= pend_d;
         count_q <= count_d;
         cmp_q   <= cmp_d;
         presc_q <= presc_d;
         pcnt_q  <= pcnt_d;
         data_q  <= data_d;
      end
   end

   assign dev_data_o = data_q;
   assign int_req_o  = pend_q & ie_q;
endmodule

// File: doc/miriscv_timer.md
MIRISCV_TIMER -- requirements
Module: miriscv_timer

Interface
REQ-001 SHALL have parameter PRESC_W, default 16, prescaler register and counter width (1..32).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous active-high reset, sampled on rising edge of clk.
REQ-004 SHALL have port dev_req_i  input  1  bus access strobe from the LSU side, one cycle per access.
REQ-005 SHALL have port dev_we_i  input  1  1 = write, 0 = read; valid with dev_req_i.
REQ-006 SHALL have port dev_mask_i  input  4  byte-enable for writes; bit n enables byte n.
REQ-007 SHALL have port dev_addr_i  input  32  byte address; only bits [3:2] decoded.
REQ-008 SHALL have port dev_wr_data_i  input  32  write data.
REQ-009 SHALL have port dev_data_o  output  32  registered read data.
REQ-010 SHALL have port int_rst_i  input  1  interrupt acknowledge from the interrupt controller.
REQ-011 SHALL have port int_req_o  output  1  level interrupt request toward the interrupt controller.

Function
REQ-012 SHALL decode [3:2]: 0 CTRL, 1 COUNT, 2 COMPARE, 3 PRESCALE (low PRESC_W bits, upper bits read 0).
REQ-013 SHALL define CTRL bits: [0] EN, [1] AUTO_RELOAD, [2] IE, [3] PEND (read; write 1 clears), [31:4] read 0.
REQ-014 SHALL update on write (dev_req_i & dev_we_i) only bytes whose dev_mask_i bit is 1; dev_mask_i = 0 changes nothing.
REQ-015 SHALL register reads: on a read access dev_data_o loads the addressed register's pre-edge value; dev_data_o holds its value in all other cycles (1-cycle latency).
REQ-016 SHALL, while EN = 1, increment the prescaler counter each cycle; when it equals PRESCALE, reset it to 0 and assert an internal tick for that cycle; PRESCALE = 0 gives a tick every cycle.
REQ-017 SHALL hold the prescaler counter at 0 while EN = 0; a write setting EN starts counting from 0.
REQ-018 SHALL on tick: if COUNT == COMPARE, set PEND; then COUNT <= 0 if AUTO_RELOAD = 1, else COUNT holds and EN <= 0 (one-shot); otherwise COUNT <= COUNT + 1 modulo 2^32.
REQ-019 SHALL give a bus write to COUNT priority over the tick update in the same cycle; the tick's PEND set still occurs if its compare was true.
REQ-020 SHALL give a bus write to CTRL.EN priority over the one-shot EN clear in the same cycle.
REQ-021 SHALL drive int_req_o = PEND & IE combinationally from registered state.
REQ-022 SHALL clear PEND when int_rst_i = 1 or on a CTRL write with mask bit 0 set and data bit 3 = 1.
REQ-023 SHALL give PEND set priority over any clear in the same cycle.
REQ-024 SHALL keep COUNT, COMPARE and PRESCALE unchanged by PEND set/clear.

Reset
REQ-025 SHALL, on reset = 1 at a clock edge, set CTRL = 0, COUNT = 0, COMPARE = 0xFFFFFFFF, PRESCALE = 0, prescaler counter = 0, PEND = 0, dev_data_o = 0.
REQ-026 SHALL give reset priority over every bus access, tick and int_rst_i in the same cycle; int_req_o = 0 the cycle after reset.
REQ-027 SHALL abort any in-progress count on reset with no pending interrupt retained.

Verification
REQ-028 SHALL cover periodic: PRESCALE=0, COMPARE=3, CTRL=0x7 -> int_req_o rises 4 cycles after the write edge, COUNT reads 0 afterwards, repeats every 4 ticks.
REQ-029 SHALL cover one-shot: PRESCALE=2, COMPARE=1, CTRL=0x5 -> PEND after 6 cycles, EN reads 0, COUNT holds 1, no further PEND after clear.
REQ-030 SHALL cover ack: int_req_o high, pulse int_rst_i 1 cycle -> int_req_o low next cycle; int_rst_i coincident with new tick match -> int_req_o stays 1.
REQ-031 SHALL cover byte mask: COMPARE=0, write 0xAABBCCDD with mask 4'b0101 -> COMPARE reads 0x00BB00DD one cycle after the read request.
REQ-032 SHALL cover wrap: COUNT=0xFFFFFFFF, COMPARE=5, EN=1, PRESCALE=0 -> next COUNT reads 0, no PEND.
REQ-033 SHALL cover reset mid-count with PEND=1 -> all registers at REQ-025 values, int_req_o=0, dev_data_o=0.
